// File: rtl/timer.sv
// Free-running periodic timer: counts 0..DELAY-1 and strobes done for one cycle
// while the count sits at DELAY-1.
module timer #(
  parameter int DELAY = 16
) (
  input  logic clk,
  input  logic rst,
  output logic done
);

  localparam int W = $clog2(DELAY);
  localparam logic [W-1:0] LAST = W'(DELAY - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);

  // Period counter; wraps explicitly at LAST so non-power-of-two periods never overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= W'(0);
    end else if (w_at_last) begin
      r_count <= W'(0);
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  // Decoded purely from the count register, so reset reaches done only through r_count.
  assign done = w_at_last;

endmodule

// File: tb/tb_timer.sv
// Scoreboarded bench for timer at DELAY = 16, 10 and 2 with directed and random resets.
module tb_timer;

  logic clk = 1'b0;
  logic rst;
  logic done16, done10, done2;

  always #5 clk = ~clk;

  timer #(.DELAY(16)) u_d16 (.clk(clk), .rst(rst), .done(done16));
  timer #(.DELAY(10)) u_d10 (.clk(clk), .rst(rst), .done(done10));
  timer #(.DELAY(2))  u_d2  (.clk(clk), .rst(rst), .done(done2));

  bit exp_q16[$];
  bit exp_q10[$];
  bit exp_q2[$];

  int checks   = 0;
  int failures = 0;
  int pulses16 = 0;

  // Reference: k = edges since the last reset edge; the count is k mod DELAY.
  int k16 = 0;
  int k10 = 0;
  int k2  = 0;

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    if (r) begin
      k16 = 0;
      k10 = 0;
      k2  = 0;
    end else begin
      k16++;
      k10++;
      k2++;
    end
    exp_q16.push_back((k16 % 16) == 15);
    exp_q10.push_back((k10 % 10) == 9);
    exp_q2.push_back((k2 % 2) == 1);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle presents a done value; pop and compare away from the clock edge.
  always @(negedge clk) begin
    bit e;
    if (exp_q16.size() > 0) begin
      e = exp_q16.pop_front();
      checks++;
      if (done16 !== e) begin
        failures++;
        $display("FAIL done16 got=%0b want=%0b t=%0t", done16, e, $time);
      end
      if (done16 === 1'b1) pulses16++;
    end
    if (exp_q10.size() > 0) begin
      e = exp_q10.pop_front();
      checks++;
      if (done10 !== e) begin
        failures++;
        $display("FAIL done10 got=%0b want=%0b t=%0t", done10, e, $time);
      end
      checks++;
      if (u_d10.r_count > 4'd9) begin
        failures++;
        $display("FAIL count10_range got=%0d want<=9 t=%0t", u_d10.r_count, $time);
      end
    end
    if (exp_q2.size() > 0) begin
      e = exp_q2.pop_front();
      checks++;
      if (done2 !== e) begin
        failures++;
        $display("FAIL done2 got=%0b want=%0b t=%0t", done2, e, $time);
      end
    end
  end

  initial begin
    rst = 1'b1;

    // One reset cycle then 50 free-running edges: pulses after E15, E31, E47.
    step(1'b1);
    @(negedge clk);
    #1;
    pulses16 = 0;
    repeat (50) step(1'b0);
    @(negedge clk);
    #1;
    check_int("pulses16_first50", pulses16, (50 + 1) / 16);

    // Reset at E20 (count 4): next pulse after the 15th edge past release, none at old E31.
    step(1'b1);
    repeat (19) step(1'b0);
    step(1'b1);
    @(negedge clk);
    #1;
    pulses16 = 0;
    repeat (20) step(1'b0);
    @(negedge clk);
    #1;
    check_int("pulses16_after_mid_reset", pulses16, 1);

    // Reset on the edge where done is high: no extra pulse, restart from zero.
    step(1'b1);
    repeat (15) step(1'b0);
    step(1'b1);
    @(negedge clk);
    #1;
    pulses16 = 0;
    repeat (14) step(1'b0);
    @(negedge clk);
    #1;
    check_int("pulses16_no_extra_after_done_reset", pulses16, 0);
    repeat (6) step(1'b0);

    // Reset held several cycles: outputs pinned low.
    @(negedge clk);
    #1;
    pulses16 = 0;
    repeat (20) step(1'b1);
    @(negedge clk);
    #1;
    check_int("pulses16_held_reset", pulses16, 0);

    // Random reset pattern against the model.
    repeat (600) step($urandom_range(0, 19) == 0);

    @(negedge clk);
    #1;
    check_int("scoreboard_drained", exp_q16.size() + exp_q10.size() + exp_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
